// File: rtl/switch_poll_pkg.sv
// Shared definitions for the switch poll controller.
// Slave register offsets, PIO offset and FSM state encoding.
package switch_poll_pkg;

  localparam logic [1:0] REG_VALUE  = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_MASK   = 2'd2;
  localparam logic [1:0] REG_EDGE   = 2'd3;

  localparam logic [1:0] PIO_DATA_OFS = 2'd0;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT_DATA,
    UPDATE
  } poll_state_t;

endpackage

// File: rtl/switch_debounce.sv
// Sample debouncer: accepts a value after DEBOUNCE_SAMPLES equal samples.
// Ports: clk, reset_n, sample/sample_valid in; stable, edge_set (comb pulse) out.
module switch_debounce
  import switch_poll_pkg::*;
#(
  parameter int WIDTH            = 18,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] edge_set
);

  localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CW-1:0] NMAX = CW'(DEBOUNCE_SAMPLES);

  logic [WIDTH-1:0] candidate;
  logic [WIDTH-1:0] cand_nxt;
  logic [WIDTH-1:0] stable_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    cnt_nxt;

  always_comb begin
    cand_nxt   = candidate;
    cnt_nxt    = count;
    stable_nxt = stable;
    edge_set   = '0;
    if (sample_valid) begin
      cand_nxt = sample;
      if (sample != candidate)
        cnt_nxt = CW'(1);
      else if (count < NMAX)
        cnt_nxt = count + CW'(1);
      // accept once the run length reaches the threshold
      if (cnt_nxt == NMAX && cand_nxt != stable) begin
        edge_set   = stable ^ cand_nxt;
        stable_nxt = cand_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate <= '0;
      count     <= '0;
      stable    <= '0;
    end else begin
      candidate <= cand_nxt;
      count     <= cnt_nxt;
      stable    <= stable_nxt;
    end
  end

endmodule

// File: rtl/switch_poll_ctrl.sv
// Periodic PIO switch poller with debounce, edge capture and level IRQ.
// Ports: clk, reset_n; Avalon-MM master m_* to PIO; Avalon-MM slave s_*; irq.
module switch_poll_ctrl
  import switch_poll_pkg::*;
#(
  parameter int WIDTH            = 18,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int PERIOD_RESET     = 50000,
  parameter int PERIOD_W         = 24,
  parameter int TIMEOUT          = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  poll_state_t state;
  poll_state_t state_nxt;

  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] timer;
  logic [PERIOD_W-1:0] limit;
  logic [TW-1:0]       tcnt;
  logic [WIDTH-1:0]    sample;
  logic [WIDTH-1:0]    stable;
  logic [WIDTH-1:0]    edge_set;
  logic [WIDTH-1:0]    edge_cap;
  logic [WIDTH-1:0]    edge_nxt;
  logic [WIDTH-1:0]    irq_mask;
  logic [WIDTH-1:0]    mask_nxt;
  logic [WIDTH-1:0]    clr;
  logic [31:0]         rd_mux;
  logic                wr_period;
  logic                wr_mask;
  logic                wr_edge;
  logic                time_up;

  logic unused_bits;
  assign unused_bits = ^{m_readdata[31:WIDTH], s_writedata[31:PERIOD_W]};

  // a stored period of 0 behaves like 1
  assign limit   = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign time_up = (timer >= limit);

  assign m_address = PIO_DATA_OFS;
  assign m_read    = (state == READ);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (time_up) state_nxt = READ;
      READ:      if (!m_waitrequest) state_nxt = WAIT_DATA;
      WAIT_DATA: begin
        if (m_readdatavalid)
          state_nxt = UPDATE;
        else if (tcnt == TLAST)
          state_nxt = IDLE;
      end
      UPDATE:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer  <= '0;
      tcnt   <= '0;
      sample <= '0;
    end else begin
      if (state == IDLE)
        timer <= time_up ? '0 : timer + PERIOD_W'(1);
      if (state == READ)
        tcnt <= '0;
      else if (state == WAIT_DATA)
        tcnt <= tcnt + TW'(1);
      if (state == WAIT_DATA && m_readdatavalid)
        sample <= m_readdata[WIDTH-1:0];
    end
  end

  switch_debounce #(
    .WIDTH            (WIDTH),
    .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample       (sample),
    .sample_valid (state == UPDATE),
    .stable       (stable),
    .edge_set     (edge_set)
  );

  assign wr_period = s_write && (s_address == REG_PERIOD);
  assign wr_mask   = s_write && (s_address == REG_MASK);
  assign wr_edge   = s_write && (s_address == REG_EDGE);

  // new edges override a same-cycle clear
  assign clr      = wr_edge ? s_writedata[WIDTH-1:0] : '0;
  assign edge_nxt = (edge_cap & ~clr) | edge_set;
  assign mask_nxt = wr_mask ? s_writedata[WIDTH-1:0] : irq_mask;

  always_comb begin
    rd_mux = '0;
    unique case (s_address)
      REG_VALUE:  rd_mux = 32'(stable);
      REG_PERIOD: rd_mux = 32'(period);
      REG_MASK:   rd_mux = 32'(irq_mask);
      REG_EDGE:   rd_mux = 32'(edge_cap);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period     <= PERIOD_W'(PERIOD_RESET);
      irq_mask   <= '0;
      edge_cap   <= '0;
      irq        <= 1'b0;
      s_readdata <= '0;
    end else begin
      if (wr_period)
        period <= s_writedata[PERIOD_W-1:0];
      irq_mask <= mask_nxt;
      edge_cap <= edge_nxt;
      irq      <= |(edge_nxt & mask_nxt);
      if (s_read)
        s_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_switch_poll_ctrl.sv
// Randomized self-checking bench for switch_poll_ctrl.
// Reference model: last-N-sample history decides acceptance.
module tb_switch_poll_ctrl;
  import switch_poll_pkg::*;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic [1:0]  s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        irq;

  always #5 clk = ~clk;

  switch_poll_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .s_address       (s_address),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_readdata      (s_readdata),
    .irq             (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] m_stable;
  logic [17:0] m_edge;
  logic [17:0] m_mask;
  logic [17:0] hist[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_stable = '0;
    m_edge   = '0;
    m_mask   = '0;
    hist.delete();
  endtask

  // accepted when the last DEB samples all equal a new value
  task automatic model_sample(input logic [17:0] v,
                              output logic [17:0] set);
    bit same;
    set = '0;
    hist.push_back(v);
    while (hist.size() > DEB) void'(hist.pop_front());
    same = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != v) same = 0;
    if (same && v != m_stable) begin
      set      = m_stable ^ v;
      m_stable = v;
    end
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    s_address = a;
    s_read    = 1'b1;
    @(negedge clk);
    s_read = 1'b0;
    d      = s_readdata;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    s_address   = a;
    s_writedata = d;
    s_write     = 1'b1;
    @(negedge clk);
    s_write = 1'b0;
    if (a == REG_MASK) m_mask = d[17:0];
    if (a == REG_EDGE) m_edge = m_edge & ~d[17:0];
  endtask

  task automatic check_regs();
    logic [31:0] d;
    reg_rd(REG_VALUE, d);
    chk("value", d, 32'(m_stable));
    reg_rd(REG_EDGE, d);
    chk("edge", d, 32'(m_edge));
    chk("irq", irq, |(m_edge & m_mask));
  endtask

  task automatic poll(input logic [17:0] v, input int ws, input int lat,
                      input bit give, input logic [17:0] clr);
    int n;
    logic [17:0] set;
    logic old_irq;
    n = 0;
    while (m_read !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("poll_start", m_read, 1);
    if (m_read !== 1'b1) return;
    chk("m_address", m_address, 0);
    for (int i = 0; i < ws; i++) begin
      @(negedge clk);
      chk("m_read_hold", m_read, 1);
    end
    m_waitrequest = 1'b0;
    @(negedge clk);
    m_waitrequest = 1'b1;
    chk("m_read_drop", m_read, 0);
    if (!give) begin
      repeat (250) @(negedge clk);
      chk("timeout_wait", m_read, 0);
      repeat (20) @(negedge clk);
      chk("timeout_idle", m_read, 1);
      return;
    end
    repeat (lat - 1) @(negedge clk);
    m_readdatavalid = 1'b1;
    m_readdata      = {14'($urandom), v};
    @(negedge clk);
    m_readdatavalid = 1'b0;
    m_readdata      = '0;
    old_irq = |(m_edge & m_mask);
    if (clr != '0) begin
      s_address   = REG_EDGE;
      s_writedata = 32'(clr);
      s_write     = 1'b1;
    end
    chk("irq_pre", irq, old_irq);
    @(negedge clk);
    s_write = 1'b0;
    model_sample(v, set);
    m_edge = (m_edge & ~clr) | set;
    chk("irq_post", irq, |(m_edge & m_mask));
  endtask

  initial begin
    logic [31:0] d;
    logic [17:0] v;
    int first;
    logic [17:0] bounce [6];

    reset_n         = 1'b0;
    m_waitrequest   = 1'b1;
    m_readdata      = '0;
    m_readdatavalid = 1'b0;
    s_address       = '0;
    s_read          = 1'b0;
    s_write         = 1'b0;
    s_writedata     = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_m_read", m_read, 0);
    chk("rst_irq", irq, 0);
    chk("rst_readdata", s_readdata, 0);
    reset_n = 1'b1;

    first = 0;
    for (int n = 1; n <= 50020; n++) begin
      @(negedge clk);
      if (m_read === 1'b1) begin
        first = n;
        break;
      end
    end
    chk("first_poll_cycle", first, 50000);
    chk("first_poll_addr", m_address, 0);
    reg_rd(REG_VALUE, d);  chk("rst_value", d, 0);
    reg_rd(REG_PERIOD, d); chk("rst_period", d, 50000);
    reg_rd(REG_MASK, d);   chk("rst_mask", d, 0);
    reg_rd(REG_EDGE, d);   chk("rst_edge", d, 0);

    reg_wr(REG_PERIOD, 10);
    reg_rd(REG_PERIOD, d); chk("period_rb", d, 10);
    reg_wr(REG_VALUE, 32'h3ffff);
    reg_wr(REG_MASK, 1);
    reg_rd(REG_MASK, d); chk("mask_rb", d, 1);
    for (int i = 0; i < 4; i++) begin
      poll(18'h5, 0, 1, 1, '0);
      reg_rd(REG_VALUE, d);
      chk("p5_value", d, (i == 3) ? 32'h5 : 32'h0);
      check_regs();
    end
    reg_rd(REG_EDGE, d); chk("p5_edge", d, 32'h5);
    chk("p5_irq", irq, 1);

    for (int i = 0; i < 4; i++) poll(18'h0, 1, 2, 1, '0);
    reg_wr(REG_EDGE, 32'h3ffff);
    check_regs();
    bounce = '{18'h1, 18'h0, 18'h1, 18'h1, 18'h1, 18'h1};
    for (int i = 0; i < 6; i++) begin
      poll(bounce[i], 0, 1, 1, '0);
      reg_rd(REG_VALUE, d);
      chk("bounce_value", d, (i == 5) ? 32'h1 : 32'h0);
      reg_rd(REG_EDGE, d);
      chk("bounce_edge", d, (i == 5) ? 32'h1 : 32'h0);
    end

    poll(18'h1, 20, 1, 0, '0);
    check_regs();
    reg_rd(REG_VALUE, d); chk("timeout_value", d, 1);

    reg_wr(REG_EDGE, 1);
    chk("clr_irq", irq, 0);
    for (int i = 0; i < 3; i++) poll(18'h0, 0, 1, 1, '0);
    poll(18'h0, 0, 1, 1, 18'h1);
    reg_rd(REG_EDGE, d); chk("collide_edge", d, 1);
    chk("collide_irq", irq, 1);
    reg_wr(REG_EDGE, 1);
    chk("w1c_irq", irq, 0);
    reg_rd(REG_EDGE, d); chk("w1c_edge", d, 0);

    reg_wr(REG_PERIOD, 0);
    reg_rd(REG_PERIOD, d); chk("period0_rb", d, 0);
    poll(m_stable, 0, 1, 1, '0);
    poll(m_stable, 0, 1, 1, '0);
    reg_wr(REG_PERIOD, 10);

    v = m_stable;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) v = 18'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        reg_wr(REG_MASK, $urandom);
        chk("rnd_mask_irq", irq, |(m_edge & m_mask));
      end
      poll(v, $urandom_range(0, 3), $urandom_range(1, 3), 1,
           ($urandom_range(0, 4) == 0) ? 18'($urandom) : 18'h0);
      check_regs();
    end

    poll(v, 0, 1, 1, '0);
    while (m_read !== 1'b1) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_drop", m_read, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    m_readdatavalid = 1'b1;
    m_readdata      = 32'hffffffff;
    @(negedge clk);
    m_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    reg_rd(REG_VALUE, d);  chk("post_rst_value", d, 0);
    reg_rd(REG_PERIOD, d); chk("post_rst_period", d, 50000);
    reg_rd(REG_MASK, d);   chk("post_rst_mask", d, 0);
    reg_rd(REG_EDGE, d);   chk("post_rst_edge", d, 0);
    chk("post_rst_irq", irq, 0);
    chk("post_rst_m_read", m_read, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/switch_poll_ctrl.md
Name: switch_poll_ctrl

Overview:
- Sequencer for the 18-bit slider-switch PIO input port.
- Acts as an Avalon-MM master that periodically reads the PIO data register (offset 0), then debounces the samples.
- Publishes the stable switch value, per-bit change flags and a level IRQ to the Nios II through its own Avalon-MM slave.
- The CPU no longer polls or debounces the switches in software.

Parameters:
- WIDTH, 18, switch bits handled; bits above WIDTH read as 0.
- DEBOUNCE_SAMPLES, 4, consecutive identical samples required before accepting a new value (>=1).
- PERIOD_RESET, 50000, reset value of the poll period register in clk cycles (1 ms at 50 MHz).
- PERIOD_W, 24, width of the period register and timer.
- TIMEOUT, 255, max cycles waiting for m_readdatavalid before the sample is abandoned.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous assert, active-low
- m_address  out  2  master word address to the PIO; constant 0
- m_read  out  1  master read request
- m_waitrequest  in  1  interconnect stall
- m_readdata  in  32  PIO read data; bits [WIDTH-1:0] used
- m_readdatavalid  in  1  read data valid
- s_address  in  2  slave register select
- s_read  in  1  slave read strobe
- s_write  in  1  slave write strobe
- s_writedata  in  32  slave write data
- s_readdata  out  32  slave read data, registered, latency 1
- irq  out  1  level interrupt: |(edge_capture & irq_mask)

Behaviour:
- Reset values: m_read=0, s_readdata=0, irq=0.
- Reset values: stable=0, candidate=0, count=0, edge_capture=0, irq_mask=0, period=PERIOD_RESET, timer=0, FSM=IDLE.
- Async reset mid-transaction drops m_read immediately. Any late readdatavalid after reset is ignored because the FSM is not in WAIT_DATA.
- Slave map:
  - 0: stable value (RO).
  - 1: period (RW, low PERIOD_W bits).
  - 2: irq_mask (RW, low WIDTH bits).
  - 3: edge_capture (RO, write-1-to-clear).
  - Writes to RO registers are ignored.
  - Reads update s_readdata the cycle after s_read; s_readdata holds its value otherwise.
- A period write of 0 is stored as 0 but treated as 1.
- IDLE: timer increments each cycle. When timer >= max(period,1)-1, clear timer and go to READ. Comparing with >= means a smaller period written mid-count takes effect immediately.
- READ: assert m_read with m_address=0. Hold until sampled with m_waitrequest=0, then deassert next cycle and go to WAIT_DATA with the timeout counter cleared.
- WAIT_DATA:
  - On m_readdatavalid, latch sample=m_readdata[WIDTH-1:0] and go to UPDATE.
  - If TIMEOUT cycles pass with no valid, return to IDLE. The sample is discarded and debounce state is unchanged.
- UPDATE (1 cycle), then IDLE:
  - If sample != candidate: candidate<=sample, count<=1.
  - Else if count < DEBOUNCE_SAMPLES: count<=count+1.
  - When the resulting count equals DEBOUNCE_SAMPLES and candidate != stable: edge_capture |= stable^candidate, then stable<=candidate.
  - count saturates at DEBOUNCE_SAMPLES.
  - With DEBOUNCE_SAMPLES=1, every differing sample is accepted immediately.
- Edge set and W1C on the same bit in the same cycle: set wins.
- irq is registered from the next-state edge_capture and irq_mask, so it asserts 1 cycle after the UPDATE that sets the bit. It deasserts 1 cycle after the clear or mask write.
- Only one master read is outstanding at a time. The timer does not run outside IDLE, so the effective poll interval is period plus transaction latency.

Decomposition:
- Shared package switch_poll_pkg holds:
  - register offsets REG_VALUE=0, REG_PERIOD=1, REG_MASK=2, REG_EDGE=3;
  - FSM state encoding IDLE/READ/WAIT_DATA/UPDATE;
  - PIO data offset constant 0.
- One natural sub-module: switch_debounce, holding candidate/count/stable/edge-set logic. Inputs: sample, sample_valid. Outputs: stable, edge_set pulse vector.
- The FSM, timer and register file stay in the top module.

Test Plan:
- Reset, then read all four registers -> 0, 50000, 0, 0; irq=0; m_read stays 0 for 49999 cycles, then asserts with m_address=0.
- Period=10, PIO returns 0x00005 for 4 polls -> REG_VALUE=0x00005, REG_EDGE=0x00005 after the 4th UPDATE. With mask=0x00001, irq=1 one cycle later.
- Bounce 0x1,0x0,0x1,0x1,0x1,0x1 from stable 0 -> REG_VALUE changes to 0x1 only after the 6th sample; no earlier edge bits set.
- m_waitrequest held high 20 cycles -> m_read held steady for 20 cycles, exactly one read completes; then no readdatavalid for 255 cycles -> FSM back to IDLE, state unchanged.
- W1C of REG_EDGE bit 0 in the same cycle UPDATE sets bit 0 -> bit 0 remains 1 and irq stays 1. A later write of 0x1 clears it and irq=0 next cycle.
- reset_n pulsed low while m_read=1 -> m_read=0 immediately, all registers at reset values, and a readdatavalid arriving after release changes nothing.
